uni: RTL and testbench

UNI -- requirements
Module: uni

---
 rtl/uni_pkg.sv | 37 +++
 rtl/uni_conv.sv | 22 ++
 rtl/uni.sv | 28 ++
 tb/tb_uni.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uni_pkg.sv
// Shared width constants and Gray-code conversion helpers for the uni block.
// The helpers work on a zero-extended word and mask the result to w bits.
package uni_pkg;

  localparam int UNI_WIDTH     = 4;
  localparam int UNI_MAX_WIDTH = 32;

  typedef logic [UNI_MAX_WIDTH-1:0] uni_word_t;

  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } uni_mode_t;

  function automatic uni_word_t width_mask(input int w);
    uni_word_t m;
    if (w >= UNI_MAX_WIDTH) m = '1;
    else                    m = (uni_word_t'(1) << w) - uni_word_t'(1);
    return m;
  endfunction

  function automatic uni_word_t bin2gray(input uni_word_t x, input int w);
    return (x ^ (x >> 1)) & width_mask(w);
  endfunction

  // Prefix XOR from the top bit down; zero-extended bits above w leave it unaffected.
  function automatic uni_word_t gray2bin(input uni_word_t g, input int w);
    uni_word_t r;
    r = '0;
    r[UNI_MAX_WIDTH-1] = g[UNI_MAX_WIDTH-1];
    for (int i = UNI_MAX_WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r & width_mask(w);
  endfunction

endpackage

// File: rtl/uni_conv.sv
// Combinational mode-selected conversion: b=0 binary-to-Gray, b=1 Gray-to-binary.
// Zero latency, no handshake.
module uni_conv
  import uni_pkg::*;
#(
  parameter int WIDTH = UNI_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    if (uni_mode_t'(b) == MODE_G2B) begin
      y = WIDTH'(gray2bin(UNI_MAX_WIDTH'(a), WIDTH));
    end else begin
      y = WIDTH'(bin2gray(UNI_MAX_WIDTH'(a), WIDTH));
    end
  end

endmodule

// File: rtl/uni.sv
// Registered binary/Gray converter; 1-cycle latency, new result every edge, no backpressure.
// Asynchronous active-low reset clears the output register immediately.
module uni
  import uni_pkg::*;
#(
  parameter int WIDTH = UNI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] conv_dat;

  uni_conv #(.WIDTH(WIDTH)) u_conv (
    .a (a),
    .b (b),
    .y (conv_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c <= '0;
    else        c <= conv_dat;
  end

endmodule

// File: tb/tb_uni.sv
// Directed self-checking bench for uni (WIDTH=4) using a hand-written Gray table.
module tb_uni;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic       b;
  logic [3:0] c;

  int errors;
  int checks;

  uni #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reflected Gray code of 0..15, written out by hand.
  function automatic logic [3:0] gray_of(input int i);
    logic [3:0] g;
    case (i)
      0: g = 4'b0000;  1: g = 4'b0001;  2: g = 4'b0011;  3: g = 4'b0010;
      4: g = 4'b0110;  5: g = 4'b0111;  6: g = 4'b0101;  7: g = 4'b0100;
      8: g = 4'b1100;  9: g = 4'b1101; 10: g = 4'b1111; 11: g = 4'b1110;
      12: g = 4'b1010; 13: g = 4'b1011; 14: g = 4'b1001; 15: g = 4'b1000;
      default: g = 4'bxxxx;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] bin_of(input logic [3:0] g);
    logic [3:0] r;
    r = 4'bxxxx;
    for (int i = 0; i < 16; i++) begin
      if (gray_of(i) == g) r = 4'(i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] av, input logic bv);
    @(negedge clk);
    a = av;
    b = bv;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] fed;
    errors = 0;
    checks = 0;
    a      = 4'b1010;
    b      = 1'b1;
    rst_n  = 1'b0;

    // Reset state, held across edges with live inputs
    #2;
    chk("reset_initial", c, 4'b0000);
    edge_settle();
    chk("reset_hold_edge1", c, 4'b0000);
    drive(4'b1111, 1'b0);
    edge_settle();
    chk("reset_hold_edge2", c, 4'b0000);

    // First edge after release samples normally
    @(negedge clk);
    rst_n = 1'b1;
    a     = 4'b0101;
    b     = 1'b0;
    edge_settle();
    chk("first_after_reset", c, 4'b0111);

    // Exhaustive sweep, each setting held two cycles
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0);
      edge_settle();
      chk("sweep_b2g_c1", c, gray_of(i));
      edge_settle();
      chk("sweep_b2g_c2", c, gray_of(i));
      drive(4'(i), 1'b1);
      edge_settle();
      chk("sweep_g2b_c1", c, bin_of(4'(i)));
      edge_settle();
      chk("sweep_g2b_c2", c, bin_of(4'(i)));
    end

    // Spot values
    drive(4'b0101, 1'b0); edge_settle(); chk("spot_0101_b0", c, 4'b0111);
    drive(4'b0101, 1'b1); edge_settle(); chk("spot_0101_b1", c, 4'b0110);
    drive(4'b1111, 1'b0); edge_settle(); chk("spot_1111_b0", c, 4'b1000);
    drive(4'b1111, 1'b1); edge_settle(); chk("spot_1111_b1", c, 4'b1010);
    drive(4'b1000, 1'b1); edge_settle(); chk("spot_1000_b1", c, 4'b1111);

    // Round trip through both modes
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0);
      edge_settle();
      fed = c;
      drive(fed, 1'b1);
      edge_settle();
      chk("round_trip", c, 4'(i));
    end

    // Latency: input change between edges must not reach c early
    drive(4'b0011, 1'b0);
    edge_settle();
    chk("latency_pre", c, 4'b0010);
    drive(4'b1100, 1'b0);
    #1;
    chk("latency_hold", c, 4'b0010);
    edge_settle();
    chk("latency_update", c, 4'b1010);

    // Async reset mid-cycle with c=1010
    drive(4'b1111, 1'b1);
    edge_settle();
    chk("async_pre", c, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_immediate", c, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      drive(4'(5 + k), k[0]);
      edge_settle();
      chk("async_held", c, 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a     = 4'b0101;
    b     = 1'b1;
    edge_settle();
    chk("async_release", c, 4'b0110);

    // Mode toggle with a=1000 held
    for (int k = 0; k < 4; k++) begin
      drive(4'b1000, 1'b0);
      edge_settle();
      chk("toggle_b0", c, 4'b1100);
      drive(4'b1000, 1'b1);
      #1;
      chk("toggle_lag", c, 4'b1100);
      edge_settle();
      chk("toggle_b1", c, 4'b1111);
    end

    // All-zero input in both modes
    drive(4'b0000, 1'b0); edge_settle(); chk("zero_b0", c, 4'b0000);
    drive(4'b0000, 1'b1); edge_settle(); chk("zero_b1", c, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
